// File: rtl/clahe_hist_pkg.sv
// Shared defaults, pipe-entry type and clear-engine states for the CLAHE histogram bank.
package clahe_hist_pkg;
    localparam int DEF_NUM_TILES = 64;
    localparam int DEF_BINS      = 256;
    localparam int DEF_CNT_W     = 16;

    // Pipe fields are sized for the largest supported configuration; narrower instances zero-extend.
    localparam int PIPE_TILE_W = 10;
    localparam int PIPE_BIN_W  = 12;
    localparam int PIPE_CNT_W  = 32;

    typedef struct packed {
        logic                   bank;
        logic [PIPE_TILE_W-1:0] tile;
        logic [PIPE_BIN_W-1:0]  bin;
        logic [PIPE_CNT_W-1:0]  cnt;
    } pipe_ent_t;

    typedef enum logic [1:0] {CLR_IDLE, CLR_DRAIN, CLR_SWEEP, CLR_DONE} clr_st_e;

    function automatic logic same_addr(pipe_ent_t a, pipe_ent_t b);
        return (a.bank == b.bank) && (a.tile == b.tile) && (a.bin == b.bin);
    endfunction
endpackage

// File: rtl/clahe_hist_pingpong_bank_if.sv
// Front-end / CDF-stage bus of the ping-pong histogram bank.
interface clahe_hist_pingpong_bank_if
    import clahe_hist_pkg::*;
#(
    parameter int TILE_W = $clog2(DEF_NUM_TILES),
    parameter int BIN_W  = $clog2(DEF_BINS),
    parameter int CNT_W  = DEF_CNT_W
);
    logic              inc_valid;
    logic [TILE_W-1:0] inc_tile;
    logic [BIN_W-1:0]  inc_bin;
    logic              swap_req;
    logic              active_bank;
    logic              rd_en;
    logic [TILE_W-1:0] rd_tile;
    logic [BIN_W-1:0]  rd_bin;
    logic              rd_valid;
    logic [CNT_W-1:0]  rd_data;
    logic              clear_start;
    logic              clear_busy;
    logic              clear_done;
    logic              sat_seen;

    modport master (
        output inc_valid, inc_tile, inc_bin, swap_req, rd_en, rd_tile, rd_bin, clear_start,
        input  active_bank, rd_valid, rd_data, clear_busy, clear_done, sat_seen
    );
    modport slave (
        input  inc_valid, inc_tile, inc_bin, swap_req, rd_en, rd_tile, rd_bin, clear_start,
        output active_bank, rd_valid, rd_data, clear_busy, clear_done, sat_seen
    );
endinterface

// File: rtl/clahe_hist_tdp_ram.sv
// One tile's bin counters: write on port A, registered read on port B (old data on collision).
module clahe_hist_tdp_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 16
) (
    input  logic          clka,
    input  logic          i_we_a,
    input  logic [AW-1:0] i_addr_a,
    input  logic [DW-1:0] i_din_a,
    input  logic [AW-1:0] i_addr_b,
    output logic [DW-1:0] o_dout_b
);
    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_dout;

    always_ff @(posedge clka) begin
        if (i_we_a) r_mem[i_addr_a] <= i_din_a;
        r_dout <= r_mem[i_addr_b];
    end

    assign o_dout_b = r_dout;
endmodule

// File: rtl/clahe_hist_pingpong_bank.sv
// Two banks of NUM_TILES x BINS saturating counters: one accumulates increments through a
// 3-stage read-modify-write pipe, the other serves reads and a whole-bank clear sweep.
module clahe_hist_pingpong_bank
    import clahe_hist_pkg::*;
#(
    parameter int NUM_TILES = DEF_NUM_TILES,
    parameter int BINS      = DEF_BINS,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic clka,
    input  logic rst_n,
    clahe_hist_pingpong_bank_if.slave io_bus
);
    localparam int TILE_W = $clog2(NUM_TILES);
    localparam int BIN_W  = $clog2(BINS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              r_active;
    logic [3:1]        r_vld_pipe;
    pipe_ent_t         r_s1, r_s2, r_s3;
    logic [CNT_W-1:0]  w_dout [2][NUM_TILES];
    logic [CNT_W-1:0]  w_base, w_s1_cnt;
    logic              w_sat, w_inc_ok, w_pend, w_clr_we;
    clr_st_e           r_clr_st;
    logic [BIN_W-1:0]  r_clr_addr;
    logic              r_clr_bank, r_clr_busy, r_clr_done, r_sat;
    logic              r_rd_valid, r_rd_zero, r_rd_bank;
    logic [TILE_W-1:0] r_rd_tile;
    logic              w_unused;

    // Increments aimed at a bank that is being swept are dropped.
    assign w_inc_ok = io_bus.inc_valid && !(r_clr_busy && (r_clr_bank == r_active));

    // The RAM read for S1 predates the writes of the two entries ahead of it; forward those.
    always_comb begin
        w_base = w_dout[r_s1.bank][r_s1.tile[TILE_W-1:0]];
        if (r_vld_pipe[2] && same_addr(r_s2, r_s1))      w_base = r_s2.cnt[CNT_W-1:0];
        else if (r_vld_pipe[3] && same_addr(r_s3, r_s1)) w_base = r_s3.cnt[CNT_W-1:0];
        w_sat    = r_vld_pipe[1] && (w_base == CNT_MAX);
        w_s1_cnt = (w_base == CNT_MAX) ? w_base : w_base + CNT_W'(1);
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            r_active   <= 1'b0;
            r_vld_pipe <= '0;
            r_s1       <= '0;
            r_s2       <= '0;
            r_s3       <= '0;
        end else begin
            r_active   <= r_active ^ io_bus.swap_req;
            r_vld_pipe <= {r_vld_pipe[2:1], w_inc_ok};
            r_s1.bank  <= r_active;
            r_s1.tile  <= PIPE_TILE_W'(io_bus.inc_tile);
            r_s1.bin   <= PIPE_BIN_W'(io_bus.inc_bin);
            r_s1.cnt   <= '0;
            r_s2       <= r_s1;
            r_s2.cnt   <= PIPE_CNT_W'(w_s1_cnt);
            r_s3       <= r_s2;
        end
    end

    // Clear may start only once no S1/S2 entry still has to land in the target bank.
    assign w_pend   = (r_vld_pipe[1] && (r_s1.bank == r_clr_bank)) ||
                      (r_vld_pipe[2] && (r_s2.bank == r_clr_bank));
    assign w_clr_we = (r_clr_st == CLR_SWEEP) || ((r_clr_st == CLR_DRAIN) && !w_pend);

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_st   <= CLR_IDLE;
            r_clr_addr <= '0;
            r_clr_bank <= 1'b0;
            r_clr_busy <= 1'b0;
            r_clr_done <= 1'b0;
        end else begin
            r_clr_done <= 1'b0;
            if (io_bus.clear_start) begin
                r_clr_st   <= CLR_DRAIN;
                r_clr_addr <= '0;
                r_clr_bank <= io_bus.swap_req ? r_active : ~r_active;
                r_clr_busy <= 1'b1;
            end else begin
                case (r_clr_st)
                    CLR_DRAIN: if (!w_pend) begin
                        r_clr_st   <= CLR_SWEEP;
                        r_clr_addr <= r_clr_addr + BIN_W'(1);
                    end
                    CLR_SWEEP: if (r_clr_addr == BIN_W'(BINS - 1)) begin
                        r_clr_st   <= CLR_DONE;
                        r_clr_busy <= 1'b0;
                        r_clr_done <= 1'b1;
                    end else begin
                        r_clr_addr <= r_clr_addr + BIN_W'(1);
                    end
                    default:   r_clr_st <= CLR_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            r_sat      <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_zero  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_rd_tile  <= '0;
        end else begin
            if (w_sat)                   r_sat <= 1'b1;
            else if (io_bus.clear_start) r_sat <= 1'b0;
            r_rd_valid <= io_bus.rd_en;
            r_rd_zero  <= r_clr_busy;
            r_rd_bank  <= ~r_active;
            r_rd_tile  <= io_bus.rd_tile;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic             w_clr_hit;
        logic [BIN_W-1:0] w_raddr;
        assign w_clr_hit = w_clr_we && (r_clr_bank == 1'(b));
        assign w_raddr   = (r_active == 1'(b)) ? io_bus.inc_bin : io_bus.rd_bin;
        for (genvar t = 0; t < NUM_TILES; t++) begin : g_tile
            logic w_inc_hit;
            assign w_inc_hit = r_vld_pipe[2] && (r_s2.bank == 1'(b)) &&
                               (r_s2.tile == PIPE_TILE_W'(t));
            clahe_hist_tdp_ram #(.DEPTH(BINS), .AW(BIN_W), .DW(CNT_W)) u_ram (
                .clka     (clka),
                .i_we_a   (w_clr_hit || w_inc_hit),
                .i_addr_a (w_clr_hit ? r_clr_addr : r_s2.bin[BIN_W-1:0]),
                .i_din_a  (w_clr_hit ? '0 : r_s2.cnt[CNT_W-1:0]),
                .i_addr_b (w_raddr),
                .o_dout_b (w_dout[b][t])
            );
        end
    end

    assign w_unused           = ^{r_s2.cnt, r_s3.cnt};
    assign io_bus.active_bank = r_active;
    assign io_bus.rd_valid    = r_rd_valid;
    assign io_bus.rd_data     = (r_rd_valid && !r_rd_zero) ? w_dout[r_rd_bank][r_rd_tile] : '0;
    assign io_bus.clear_busy  = r_clr_busy;
    assign io_bus.clear_done  = r_clr_done;
    assign io_bus.sat_seen    = r_sat;
endmodule

// File: tb/tb_clahe_hist_pingpong_bank.sv
// Bench for the ping-pong histogram bank: full-size instance plus a 4-bit-counter instance.
module tb_clahe_hist_pingpong_bank;
    logic clka = 1'b0;
    logic rst_n;
    always #5 clka = ~clka;

    clahe_hist_pingpong_bank_if #(.TILE_W(6), .BIN_W(8), .CNT_W(16)) bus_a ();
    clahe_hist_pingpong_bank_if #(.TILE_W(2), .BIN_W(4), .CNT_W(4))  bus_b ();

    clahe_hist_pingpong_bank #(.NUM_TILES(64), .BINS(256), .CNT_W(16)) u_dut (
        .clka(clka), .rst_n(rst_n), .io_bus(bus_a));
    clahe_hist_pingpong_bank #(.NUM_TILES(4), .BINS(16), .CNT_W(4)) u_sat (
        .clka(clka), .rst_n(rst_n), .io_bus(bus_b));

    logic       sel;
    logic       t_inc_valid, t_swap, t_rd_en, t_clear_start;
    logic [5:0] t_inc_tile, t_rd_tile;
    logic [7:0] t_inc_bin, t_rd_bin;

    assign bus_a.inc_valid   = !sel && t_inc_valid;
    assign bus_a.swap_req    = !sel && t_swap;
    assign bus_a.rd_en       = !sel && t_rd_en;
    assign bus_a.clear_start = !sel && t_clear_start;
    assign bus_a.inc_tile    = t_inc_tile;
    assign bus_a.inc_bin     = t_inc_bin;
    assign bus_a.rd_tile     = t_rd_tile;
    assign bus_a.rd_bin      = t_rd_bin;
    assign bus_b.inc_valid   = sel && t_inc_valid;
    assign bus_b.swap_req    = sel && t_swap;
    assign bus_b.rd_en       = sel && t_rd_en;
    assign bus_b.clear_start = sel && t_clear_start;
    assign bus_b.inc_tile    = t_inc_tile[1:0];
    assign bus_b.inc_bin     = t_inc_bin[3:0];
    assign bus_b.rd_tile     = t_rd_tile[1:0];
    assign bus_b.rd_bin      = t_rd_bin[3:0];

    logic        w_active, w_rd_valid, w_busy, w_done, w_sat;
    logic [15:0] w_rd_data;
    assign w_active   = sel ? bus_b.active_bank : bus_a.active_bank;
    assign w_rd_valid = sel ? bus_b.rd_valid    : bus_a.rd_valid;
    assign w_busy     = sel ? bus_b.clear_busy  : bus_a.clear_busy;
    assign w_done     = sel ? bus_b.clear_done  : bus_a.clear_done;
    assign w_sat      = sel ? bus_b.sat_seen    : bus_a.sat_seen;
    assign w_rd_data  = sel ? {12'd0, bus_b.rd_data} : bus_a.rd_data;

    typedef struct {
        int tile;
        int bin;
        int exp;
    } rd_vec_t;

    int          n_pass = 0;
    int          n_tot  = 0;
    logic        exp_active [2];
    int unsigned mdl [2][2][4];

    task automatic tick();
        @(negedge clka);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic swap();
        t_swap = 1'b1;
        tick();
        t_swap = 1'b0;
        exp_active[sel] = !exp_active[sel];
        chk("swap_active", {31'd0, w_active}, {31'd0, exp_active[sel]});
    endtask

    task automatic rd_chk(input string nm, input int tile, input int bin, input int exp);
        t_rd_en   = 1'b1;
        t_rd_tile = 6'(tile);
        t_rd_bin  = 8'(bin);
        tick();
        t_rd_en = 1'b0;
        chk({nm, "_vld"}, {31'd0, w_rd_valid}, 32'd1);
        chk(nm, {16'd0, w_rd_data}, 32'(exp));
    endtask

    // Pulse clear, count busy cycles and done pulses; read tile 3 bin 17 mid-sweep.
    task automatic do_clear(input int exp_len);
        int busy_n = 0;
        int done_n = 0;
        t_clear_start = 1'b1;
        tick();
        t_clear_start = 1'b0;
        for (int cyc = 0; cyc < exp_len + 20; cyc++) begin
            if (w_busy) busy_n++;
            if (w_done) done_n++;
            if (cyc == 6) begin
                chk("clr_rd_vld", {31'd0, w_rd_valid}, 32'd1);
                chk("clr_rd_zero", {16'd0, w_rd_data}, 32'd0);
            end
            t_rd_en   = (cyc == 5);
            t_rd_tile = 6'd3;
            t_rd_bin  = 8'd17;
            tick();
        end
        t_rd_en = 1'b0;
        chk("clr_busy_len", 32'(busy_n), 32'(exp_len));
        chk("clr_done_cnt", 32'(done_n), 32'd1);
    endtask

    task automatic rst_chk(input string nm);
        chk({nm, "_active"}, {31'd0, w_active}, 32'd0);
        chk({nm, "_rdvld"},  {31'd0, w_rd_valid}, 32'd0);
        chk({nm, "_rddata"}, {16'd0, w_rd_data}, 32'd0);
        chk({nm, "_busy"},   {31'd0, w_busy}, 32'd0);
        chk({nm, "_done"},   {31'd0, w_done}, 32'd0);
        chk({nm, "_sat"},    {31'd0, w_sat}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rd_vec_t rtab [8];
        int      a;
        rtab[0] = '{3, 17, 5};
        rtab[1] = '{3, 16, 0};
        rtab[2] = '{3, 18, 0};
        rtab[3] = '{0, 7, 100};
        rtab[4] = '{0, 8, 100};
        rtab[5] = '{0, 6, 0};
        rtab[6] = '{0, 9, 0};
        rtab[7] = '{1, 7, 0};

        sel = 1'b0;
        t_inc_valid = 1'b0; t_swap = 1'b0; t_rd_en = 1'b0; t_clear_start = 1'b0;
        t_inc_tile = '0; t_inc_bin = '0; t_rd_tile = '0; t_rd_bin = '0;
        exp_active[0] = 1'b0;
        exp_active[1] = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        rst_chk("reset");

        // Clear both banks, then confirm zeros in each.
        do_clear(256);
        swap();
        do_clear(256);
        for (int i = 0; i < 4; i++)
            rd_chk("clr0_rd", int'($urandom_range(0, 63)), int'($urandom_range(0, 255)), 0);
        swap();
        for (int i = 0; i < 4; i++)
            rd_chk("clr1_rd", int'($urandom_range(0, 63)), int'($urandom_range(0, 255)), 0);

        // Back-to-back same bin, then alternating neighbours (distance-2 hits).
        for (int i = 0; i < 5; i++) begin
            t_inc_valid = 1'b1; t_inc_tile = 6'd3; t_inc_bin = 8'd17;
            tick();
        end
        for (int i = 0; i < 200; i++) begin
            t_inc_valid = 1'b1; t_inc_tile = 6'd0; t_inc_bin = (i % 2 == 1) ? 8'd8 : 8'd7;
            tick();
        end
        t_inc_valid = 1'b0;
        swap();
        repeat (3) tick();
        for (int i = 0; i < 8; i++) rd_chk("tab_rd", rtab[i].tile, rtab[i].bin, rtab[i].exp);

        // Randomised increments and swaps on a small address set against the count model.
        do_clear(256);
        for (int b = 0; b < 2; b++)
            for (int t = 0; t < 2; t++)
                for (int n = 0; n < 4; n++) mdl[b][t][n] = 0;
        for (int c = 0; c < 400; c++) begin
            int tl, bn;
            tl = int'($urandom_range(0, 1));
            bn = int'($urandom_range(0, 3));
            t_inc_valid = ($urandom_range(0, 3) != 0);
            t_inc_tile  = 6'(tl);
            t_inc_bin   = 8'(bn);
            t_swap      = ($urandom_range(0, 30) == 0);
            if (t_inc_valid) mdl[exp_active[0]][tl][bn]++;
            tick();
            if (t_swap) exp_active[0] = !exp_active[0];
        end
        t_inc_valid = 1'b0;
        t_swap = 1'b0;
        repeat (4) tick();
        for (int k = 0; k < 2; k++) begin
            for (int t = 0; t < 2; t++)
                for (int n = 0; n < 4; n++)
                    rd_chk("rand_rd", t, n, int'(mdl[!exp_active[0]][t][n]));
            if (k == 0) begin
                swap();
                repeat (4) tick();
            end
        end

        // Increment in the swap cycle goes to the old bank, the next one to the new bank.
        t_swap = 1'b1; t_inc_valid = 1'b1; t_inc_tile = 6'd5; t_inc_bin = 8'd200;
        tick();
        t_swap = 1'b0;
        exp_active[0] = !exp_active[0];
        chk("swapinc_active", {31'd0, w_active}, {31'd0, exp_active[0]});
        tick();
        t_inc_valid = 1'b0;
        repeat (4) tick();
        rd_chk("swapinc_old", 5, 200, 1);
        swap();
        repeat (4) tick();
        rd_chk("swapinc_new", 5, 200, 1);

        // Asynchronous reset in the middle of a sweep.
        if (exp_active[0] == 1'b0) swap();
        t_clear_start = 1'b1;
        tick();
        t_clear_start = 1'b0;
        repeat (50) tick();
        t_rd_en = 1'b1; t_rd_tile = 6'd0; t_rd_bin = 8'd0;
        tick();
        t_rd_en = 1'b0;
        chk("prerst_busy", {31'd0, w_busy}, 32'd1);
        chk("prerst_active", {31'd0, w_active}, 32'd1);
        #2 rst_n = 1'b0;
        #1 rst_chk("midrst");
        @(negedge clka);
        rst_n = 1'b1;
        exp_active[0] = 1'b0;
        exp_active[1] = 1'b0;
        tick();
        do_clear(256);

        // Saturation on the 4-bit instance.
        sel = 1'b1;
        a = 0;
        do_clear(16);
        swap();
        do_clear(16);
        swap();
        for (int i = 0; i < 20; i++) begin
            t_inc_valid = 1'b1; t_inc_tile = 6'd2; t_inc_bin = 8'd5;
            tick();
            if (i == 3) a = int'(w_sat);
        end
        t_inc_valid = 1'b0;
        repeat (4) tick();
        chk("sat_early", 32'(a), 32'd0);
        chk("sat_set", {31'd0, w_sat}, 32'd1);
        swap();
        repeat (3) tick();
        rd_chk("sat_rd", 2, 5, 15);
        rd_chk("sat_nb", 2, 4, 0);
        do_clear(16);
        chk("sat_cleared", {31'd0, w_sat}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
